// File: rtl/ecg_sample_writer.sv
// ecg_sample_writer: ping-pong writer that streams ECG samples into one half
// of a dual-bank BRAM while a reader drains the other half.
//   Parameters: DEPTH samples per bank (DEPTH >= 2, 2*DEPTH <= 2**ADDR_W),
//               ADDR_W BRAM port-A address width, DATA_W sample width.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     s_data/s_valid    incoming sample stream; s_ready accepts (comb from state)
//     rd_done           one-cycle pulse: reader released the bank it owns
//     wea/addra/dina    registered BRAM port-A write (1-cycle latency)
//     switch            bank being written; reader owns ~switch
//     frame_pulse       one-cycle pulse on each bank handoff
//     drop_cnt          saturating count of s_valid cycles seen while stalled
module ecg_sample_writer #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              rd_done,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              switch,
  output logic              frame_pulse,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(DEPTH);

  typedef enum logic {ST_FILL = 1'b0, ST_STALL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                switch_q, switch_d;
  logic                reader_busy_q, reader_busy_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dina_q, dina_d;
  logic                frame_q, frame_d;
  logic [7:0]          drop_q, drop_d;

  logic accept_c;
  logic bank_full_c;
  logic eff_busy_c;

  assign s_ready     = (state_q == ST_FILL);
  assign accept_c    = s_valid && s_ready;
  assign bank_full_c = accept_c && (wr_ptr_q == LAST_PTR);
  // A release arriving in the same cycle as bank full frees the reader.
  assign eff_busy_c  = reader_busy_q && !rd_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FILL;
      wr_ptr_q      <= '0;
      switch_q      <= 1'b0;
      reader_busy_q <= 1'b0;
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= '0;
      frame_q       <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      switch_q      <= switch_d;
      reader_busy_q <= reader_busy_d;
      wea_q         <= wea_d;
      addra_q       <= addra_d;
      dina_q        <= dina_d;
      frame_q       <= frame_d;
      drop_q        <= drop_d;
    end
  end

  // Next-state, write port and handoff logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    switch_d      = switch_q;
    reader_busy_d = reader_busy_q;
    wea_d         = 1'b0;
    addra_d       = addra_q;
    dina_d        = dina_q;
    frame_d       = 1'b0;
    drop_d        = drop_q;

    if (s_valid && !s_ready && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    // Address uses the pre-toggle bank, so the last sample lands in the old bank.
    if (accept_c) begin
      wea_d    = 1'b1;
      addra_d  = switch_q ? (BANK1_BASE + wr_ptr_q) : wr_ptr_q;
      dina_d   = s_data;
      wr_ptr_d = bank_full_c ? '0 : (wr_ptr_q + ADDR_W'(1));
    end

    case (state_q)
      ST_FILL: begin
        if (bank_full_c) begin
          if (!eff_busy_c) begin
            switch_d      = !switch_q;
            reader_busy_d = 1'b1;
            frame_d       = 1'b1;
          end else begin
            state_d = ST_STALL;
          end
        end else if (rd_done) begin
          reader_busy_d = 1'b0;
        end
      end
      ST_STALL: begin
        // Reader hands back its bank and immediately takes the full one.
        if (rd_done) begin
          switch_d      = !switch_q;
          reader_busy_d = 1'b1;
          frame_d       = 1'b1;
          state_d       = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign wea         = wea_q;
  assign addra       = addra_q;
  assign dina        = dina_q;
  assign switch      = switch_q;
  assign frame_pulse = frame_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ecg_sample_writer.sv
// Self-checking bench for ecg_sample_writer (DEPTH=4, ADDR_W=12, DATA_W=16).
// Reference model tracks banks, fill count and reader ownership directly.
module tb_ecg_sample_writer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              rd_done;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              switch;
  logic              frame_pulse;
  logic [7:0]        drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic              m_wea;
  logic [ADDR_W-1:0] m_addra;
  logic [DATA_W-1:0] m_dina;
  logic              m_bank;     // bank being filled
  logic              m_frame;
  logic              m_waiting;  // a full bank waits for the reader
  logic              m_holds;    // reader owns an unreleased bank
  int                m_count;    // samples already in current bank
  logic [7:0]        m_drop;

  ecg_sample_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rd_done(rd_done), .wea(wea), .addra(addra), .dina(dina), .switch(switch),
    .frame_pulse(frame_pulse), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_wea = 0; m_addra = '0; m_dina = '0; m_bank = 0; m_frame = 0;
    m_waiting = 0; m_holds = 0; m_count = 0; m_drop = '0;
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit rdd);
    @(negedge clk);
    s_valid = v; s_data = d; rd_done = rdd;
    m_wea = 0; m_frame = 0;
    if (v && m_waiting) m_drop = (m_drop == 8'd255) ? 8'd255 : m_drop + 8'd1;
    if (v && !m_waiting) begin
      m_wea   = 1;
      m_addra = ADDR_W'((m_bank ? DEPTH : 0) + m_count);
      m_dina  = d;
      m_count = m_count + 1;
    end
    if (m_wea && m_count == DEPTH) begin
      m_count = 0;
      if (m_holds && !rdd) m_waiting = 1;
      else begin m_bank = ~m_bank; m_holds = 1; m_frame = 1; end
    end else if (rdd) begin
      if (m_waiting) begin m_bank = ~m_bank; m_holds = 1; m_frame = 1; m_waiting = 0; end
      else m_holds = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    s_valid = 0; rd_done = 0; s_data = '0;
    #1 rst = 1;  // asynchronous, away from any edge
    #1;
    checks++;
    if ({wea, addra, dina, switch, frame_pulse, drop_cnt, s_ready} !== {1'b0, 12'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset: wea=%0b addra=%0d dina=%0d sw=%0b fp=%0b drop=%0d rdy=%0b, want all 0 and rdy=1",
               wea, addra, dina, switch, frame_pulse, drop_cnt, s_ready);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1; s_valid = 0; rd_done = 0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wea, addra, dina, switch, frame_pulse, drop_cnt, s_ready} !== {1'b0, 12'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset: wea=%0b addra=%0d dina=%0d sw=%0b fp=%0b drop=%0d rdy=%0b, want all 0 and rdy=1",
               wea, addra, dina, switch, frame_pulse, drop_cnt, s_ready);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, DATA_W'(10 + i), 0);
      checks++;
      if ({wea, addra, dina, switch, frame_pulse, s_ready, drop_cnt} !== {m_wea, m_addra, m_dina, m_bank, m_frame, ~m_waiting, m_drop}) begin
        failures++;
        $display("FAIL fill[%0d]: got wea=%0b a=%0d d=%0d sw=%0b fp=%0b rdy=%0b drop=%0d want %0b %0d %0d %0b %0b %0b %0d",
                 i, wea, addra, dina, switch, frame_pulse, s_ready, drop_cnt, m_wea, m_addra, m_dina, m_bank, m_frame, ~m_waiting, m_drop);
      end
    end
    checks++;
    if ({switch, addra, dina} !== {1'b1, 12'd3, 16'd13}) begin
      failures++;
      $display("FAIL fill_end: sw=%0b a=%0d d=%0d want 1 3 13", switch, addra, dina);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) begin
      step(1, DATA_W'(20 + i), 0);
      checks++;
      if ({wea, addra, dina, switch, frame_pulse, s_ready, drop_cnt} !== {m_wea, m_addra, m_dina, m_bank, m_frame, ~m_waiting, m_drop}) begin
        failures++;
        $display("FAIL stall[%0d]: got wea=%0b a=%0d d=%0d sw=%0b fp=%0b rdy=%0b drop=%0d want %0b %0d %0d %0b %0b %0b %0d",
                 i, wea, addra, dina, switch, frame_pulse, s_ready, drop_cnt, m_wea, m_addra, m_dina, m_bank, m_frame, ~m_waiting, m_drop);
      end
    end
    checks++;
    if ({s_ready, drop_cnt, wea, addra} !== {1'b0, 8'd4, 1'b0, 12'd7}) begin
      failures++;
      $display("FAIL stall_end: rdy=%0b drop=%0d wea=%0b a=%0d want 0 4 0 7", s_ready, drop_cnt, wea, addra);
    end
  endtask

  task automatic test_release();
    step(0, '0, 1);
    checks++;
    if ({switch, frame_pulse, s_ready} !== {1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL release: sw=%0b fp=%0b rdy=%0b want 0 1 1", switch, frame_pulse, s_ready);
    end
    step(1, 16'h0ABC, 0);
    checks++;
    if ({wea, addra, dina, frame_pulse} !== {1'b1, 12'd0, 16'h0ABC, 1'b0}) begin
      failures++;
      $display("FAIL release_write: wea=%0b a=%0d d=%0h fp=%0b want 1 0 abc 0", wea, addra, dina, frame_pulse);
    end
  endtask

  task automatic test_coincident();
    step(1, 16'd1, 0);
    step(1, 16'd2, 0);
    step(1, 16'd3, 1);  // final sample of bank with rd_done in same cycle
    checks++;
    if ({wea, addra, switch, frame_pulse, s_ready} !== {m_wea, m_addra, m_bank, m_frame, ~m_waiting}
        || {switch, frame_pulse, s_ready, addra} !== {1'b1, 1'b1, 1'b1, 12'd3}) begin
      failures++;
      $display("FAIL coincident: wea=%0b a=%0d sw=%0b fp=%0b rdy=%0b want 1 3 1 1 1", wea, addra, switch, frame_pulse, s_ready);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DEPTH; i++) step(1, DATA_W'(i), 0);
    for (int i = 0; i < 300; i++) step(1, DATA_W'(i), 0);
    checks++;
    if ({drop_cnt, s_ready, wea} !== {8'd255, 1'b0, 1'b0} || drop_cnt !== m_drop) begin
      failures++;
      $display("FAIL saturate: drop=%0d rdy=%0b wea=%0b want 255 0 0", drop_cnt, s_ready, wea);
    end
    step(0, '0, 1);
    checks++;
    if ({drop_cnt, s_ready, frame_pulse} !== {8'd255, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL saturate_hold: drop=%0d rdy=%0b fp=%0b want 255 1 1", drop_cnt, s_ready, frame_pulse);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < DEPTH + 2; i++) step(1, DATA_W'(100 + i), 0);
    checks++;
    if ({switch, addra} !== {1'b1, 12'd5}) begin
      failures++;
      $display("FAIL pre_reset: sw=%0b a=%0d want 1 5", switch, addra);
    end
    apply_reset();
    step(1, 16'h5555, 0);
    checks++;
    if ({wea, addra, dina, switch} !== {1'b1, 12'd0, 16'h5555, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: wea=%0b a=%0d d=%0h sw=%0b want 1 0 5555 0", wea, addra, dina, switch);
    end
  endtask

  task automatic test_random();
    logic prev_fp;
    prev_fp = frame_pulse;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, DATA_W'($urandom), $urandom_range(0, 9) == 0);
      checks++;
      if ({wea, addra, dina, switch, frame_pulse, s_ready, drop_cnt} !== {m_wea, m_addra, m_dina, m_bank, m_frame, ~m_waiting, m_drop}) begin
        failures++;
        $display("FAIL random[%0d]: got wea=%0b a=%0d d=%0h sw=%0b fp=%0b rdy=%0b drop=%0d want %0b %0d %0h %0b %0b %0b %0d",
                 i, wea, addra, dina, switch, frame_pulse, s_ready, drop_cnt, m_wea, m_addra, m_dina, m_bank, m_frame, ~m_waiting, m_drop);
      end
      checks++;
      if (frame_pulse && prev_fp) begin
        failures++;
        $display("FAIL frame_twice[%0d]: frame_pulse high two cycles in a row, want single-cycle", i);
      end
      prev_fp = frame_pulse;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_release();
    test_coincident();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
